// File: rtl/load_store_unit_if.sv
// Request, memory-bus and response signals of the load/store unit.
// The unit connects to the slave modport; the requester/memory side uses master.
interface load_store_unit_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_is_store;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_wdata;
    logic        mem_ready;
    logic [31:0] mem_rdata;
    logic        rsp_valid;
    logic [31:0] rsp_data;
    logic        rsp_err;

    modport slave (
        input  req_valid, req_is_store, req_funct3, req_addr, req_wdata,
        input  mem_ready, mem_rdata,
        output req_ready, mem_req, mem_we, mem_addr, mem_wstrb, mem_wdata,
        output rsp_valid, rsp_data, rsp_err
    );

    modport master (
        output req_valid, req_is_store, req_funct3, req_addr, req_wdata,
        output mem_ready, mem_rdata,
        input  req_ready, mem_req, mem_we, mem_addr, mem_wstrb, mem_wdata,
        input  rsp_valid, rsp_data, rsp_err
    );
endinterface

// File: rtl/load_store_unit.sv
// RV32I load/store unit: one outstanding access, byte-lane steering,
// load formatting, misalignment/illegal-funct3 detection and a memory timeout.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// IDLE     | req_ready=1, waiting for a request
// WAIT_MEM | mem_req held high, waiting for mem_ready or the timeout
// RESP     | one-cycle rsp_valid pulse, then back to IDLE
module load_store_unit #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic             clk,
    input  logic             reset,
    load_store_unit_if.slave bus
);
    typedef enum logic [1:0] {IDLE, WAIT_MEM, RESP} state_t;

    localparam logic [7:0] LAST_CNT = 8'(TIMEOUT_CYCLES - 1);

    state_t      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        is_store_q, is_store_d;
    logic [2:0]  funct3_q, funct3_d;
    logic [1:0]  offset_q, offset_d;
    logic        mem_req_q, mem_req_d;
    logic        mem_we_q, mem_we_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic [3:0]  mem_wstrb_q, mem_wstrb_d;
    logic [31:0] mem_wdata_q, mem_wdata_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic [31:0] rsp_data_q, rsp_data_d;
    logic        rsp_err_q, rsp_err_d;

    logic        req_bad_funct3, req_misaligned, req_err;
    logic [3:0]  req_wstrb;
    logic [31:0] req_wdata_rep;
    logic [7:0]  rd_byte;
    logic [15:0] rd_half;
    logic [31:0] load_result;

    always_comb begin
        if (bus.req_is_store)
            req_bad_funct3 = (bus.req_funct3 > 3'd2);
        else
            req_bad_funct3 = (bus.req_funct3 == 3'd3) || (bus.req_funct3 == 3'd6) ||
                             (bus.req_funct3 == 3'd7);
        case (bus.req_funct3[1:0])
            2'd1:    req_misaligned = bus.req_addr[0];
            2'd2:    req_misaligned = (bus.req_addr[1:0] != 2'b00);
            default: req_misaligned = 1'b0;
        endcase
        req_err = req_bad_funct3 || req_misaligned;

        // Store data is replicated across lanes so memory can pick any lane by strobe.
        req_wstrb     = 4'b0000;
        req_wdata_rep = bus.req_wdata;
        if (bus.req_is_store) begin
            case (bus.req_funct3[1:0])
                2'd0: begin
                    req_wstrb     = 4'b0001 << bus.req_addr[1:0];
                    req_wdata_rep = {4{bus.req_wdata[7:0]}};
                end
                2'd1: begin
                    req_wstrb     = 4'b0011 << {bus.req_addr[1], 1'b0};
                    req_wdata_rep = {2{bus.req_wdata[15:0]}};
                end
                default: req_wstrb = 4'b1111;
            endcase
        end
    end

    always_comb begin
        case (offset_q)
            2'd0:    rd_byte = bus.mem_rdata[7:0];
            2'd1:    rd_byte = bus.mem_rdata[15:8];
            2'd2:    rd_byte = bus.mem_rdata[23:16];
            default: rd_byte = bus.mem_rdata[31:24];
        endcase
        rd_half = offset_q[1] ? bus.mem_rdata[31:16] : bus.mem_rdata[15:0];
        case (funct3_q[1:0])
            2'd0:    load_result = {{24{~funct3_q[2] & rd_byte[7]}}, rd_byte};
            2'd1:    load_result = {{16{~funct3_q[2] & rd_half[15]}}, rd_half};
            default: load_result = bus.mem_rdata;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        is_store_d  = is_store_q;
        funct3_d    = funct3_q;
        offset_d    = offset_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wstrb_d = mem_wstrb_q;
        mem_wdata_d = mem_wdata_q;
        rsp_valid_d = 1'b0;
        rsp_data_d  = 32'd0;
        rsp_err_d   = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.req_valid) begin
                    is_store_d = bus.req_is_store;
                    funct3_d   = bus.req_funct3;
                    offset_d   = bus.req_addr[1:0];
                    if (req_err) begin
                        state_d     = RESP;
                        rsp_valid_d = 1'b1;
                        rsp_err_d   = 1'b1;
                    end else begin
                        state_d     = WAIT_MEM;
                        cnt_d       = 8'd0;
                        mem_req_d   = 1'b1;
                        mem_we_d    = bus.req_is_store;
                        mem_addr_d  = {bus.req_addr[31:2], 2'b00};
                        mem_wstrb_d = req_wstrb;
                        mem_wdata_d = req_wdata_rep;
                    end
                end
            end
            WAIT_MEM: begin
                // mem_ready is checked before the timeout so a completion in the last counted cycle wins.
                if (bus.mem_ready || cnt_q == LAST_CNT) begin
                    state_d     = RESP;
                    mem_req_d   = 1'b0;
                    mem_we_d    = 1'b0;
                    mem_wstrb_d = 4'b0000;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = ~bus.mem_ready;
                    rsp_data_d  = (bus.mem_ready && !is_store_q) ? load_result : 32'd0;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= 8'd0;
            is_store_q  <= 1'b0;
            funct3_q    <= 3'd0;
            offset_q    <= 2'd0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= 32'd0;
            mem_wstrb_q <= 4'd0;
            mem_wdata_q <= 32'd0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= 32'd0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            is_store_q  <= is_store_d;
            funct3_q    <= funct3_d;
            offset_q    <= offset_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wstrb_q <= mem_wstrb_d;
            mem_wdata_q <= mem_wdata_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    assign bus.req_ready = (state_q == IDLE);
    assign bus.mem_req   = mem_req_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wstrb = mem_wstrb_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_data  = rsp_data_q;
    assign bus.rsp_err   = rsp_err_q;
endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: transaction-level model, per-cycle
// timeline compare, plus reset abort and reset-priority scenarios.
module tb_load_store_unit;
    localparam int TO = 16;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    load_store_unit_if bus ();
    load_store_unit #(.TIMEOUT_CYCLES(TO)) dut (.clk(clk), .reset(reset), .bus(bus));

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_pass = 0;
    int n_tot  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    endtask

    typedef struct packed {
        logic        err;
        logic [31:0] addr;
        logic [3:0]  wstrb;
        logic [31:0] wdata;
        logic [31:0] rsp;
    } model_t;

    // Access-level reference: size from funct3, lanes from the byte offset.
    function automatic model_t model(input logic st, input logic [2:0] f3,
                                     input logic [31:0] addr, input logic [31:0] wdata,
                                     input logic [31:0] rdata);
        model_t m;
        longint nbytes, off, mask, lane, v;
        m      = '0;
        nbytes = longint'(1) << f3[1:0];
        off    = longint'(addr % 4);
        m.err  = st ? (f3 > 3'd2) : (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7);
        if (!m.err && (longint'(addr) % nbytes) != 0) m.err = 1'b1;
        m.addr = addr - 32'(off);
        if (m.err) return m;
        mask = (longint'(1) << (8 * nbytes)) - 1;
        if (st) begin
            m.wstrb = 4'(((longint'(1) << nbytes) - 1) << off);
            lane    = longint'(wdata) & mask;
            v       = 0;
            for (int i = 0; i < 4 / nbytes; i++) v = v | (lane << (8 * nbytes * i));
            m.wdata = 32'(v);
        end else begin
            v = (longint'(rdata) >> (8 * off)) & mask;
            if (!f3[2] && nbytes < 4 && v >= (mask + 1) / 2) v = v - (mask + 1);
            m.rsp = 32'(v);
        end
        return m;
    endfunction

    // Current transaction timeline, relative to the accept edge.
    bit          chk_en  = 1'b0;
    int          tr_acc  = -100000;
    int          tr_k    = 0;
    int          tr_rsp_c = 0;
    logic        tr_mem  = 1'b0;
    logic        tr_we   = 1'b0;
    logic        tr_err  = 1'b0;
    logic [31:0] tr_addr = '0;
    logic [31:0] tr_wdata = '0;
    logic [3:0]  tr_wstrb = '0;
    logic [31:0] tr_rsp  = '0;

    always @(negedge clk) begin
        int c;
        bit in_txn, mem_on, rsp_now;
        if (chk_en) begin
            c       = cyc - tr_acc;
            in_txn  = (c >= 0) && (c <= tr_rsp_c);
            mem_on  = tr_mem && (c >= 0) && (c < tr_k);
            rsp_now = in_txn && (c == tr_rsp_c);
            chk("req_ready", 32'(bus.req_ready), 32'(!in_txn));
            chk("mem_req", 32'(bus.mem_req), 32'(mem_on));
            chk("rsp_valid", 32'(bus.rsp_valid), 32'(rsp_now));
            if (mem_on) begin
                chk("mem_addr", bus.mem_addr, tr_addr);
                chk("mem_we", 32'(bus.mem_we), 32'(tr_we));
                chk("mem_wstrb", 32'(bus.mem_wstrb), 32'(tr_wstrb));
                if (tr_we) chk("mem_wdata", bus.mem_wdata, tr_wdata);
            end
            if (rsp_now) begin
                chk("rsp_data", bus.rsp_data, tr_rsp);
                chk("rsp_err", 32'(bus.rsp_err), 32'(tr_err));
            end
        end
    end

    // k = WAIT cycle (1-based) in which mem_ready is driven; 0 = never (timeout).
    task automatic run(input string name, input logic st, input logic [2:0] f3,
                       input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [31:0] rdata, input int k, input logic exp_err,
                       input logic [3:0] exp_wstrb, input logic [31:0] exp_wdata,
                       input logic [31:0] exp_rsp);
        model_t m;
        logic   tot_err;
        logic [31:0] rsp;
        m       = model(st, f3, addr, wdata, rdata);
        tot_err = m.err || (k == 0);
        rsp     = tot_err ? 32'd0 : m.rsp;
        chk({name, "/model_err"}, 32'(tot_err), 32'(exp_err));
        chk({name, "/model_rsp"}, rsp, exp_rsp);
        if (st && !m.err) begin
            chk({name, "/model_wstrb"}, 32'(m.wstrb), 32'(exp_wstrb));
            chk({name, "/model_wdata"}, m.wdata, exp_wdata);
        end

        bus.req_valid    = 1'b1;
        bus.req_is_store = st;
        bus.req_funct3   = f3;
        bus.req_addr     = addr;
        bus.req_wdata    = wdata;
        @(posedge clk);
        #1;
        tr_acc   = cyc;
        tr_mem   = !m.err;
        tr_k     = (k == 0) ? TO : k;
        tr_rsp_c = m.err ? 0 : tr_k;
        tr_we    = st;
        tr_err   = tot_err;
        tr_addr  = m.addr;
        tr_wstrb = m.wstrb;
        tr_wdata = m.wdata;
        tr_rsp   = rsp;
        bus.req_valid = 1'b0;
        bus.req_addr  = $urandom;
        bus.req_wdata = $urandom;

        if (k != 0) begin
            repeat (k - 1) @(posedge clk);
            #1;
            bus.mem_ready = 1'b1;
            bus.mem_rdata = rdata;
            @(posedge clk);
            #1;
            bus.mem_ready = 1'b0;
            bus.mem_rdata = 32'hDEAD_BEEF;
        end
        while (cyc < tr_acc + tr_rsp_c + 1) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        bit seen;
        reset            = 1'b1;
        bus.req_valid    = 1'b0;
        bus.req_is_store = 1'b0;
        bus.req_funct3   = 3'd0;
        bus.req_addr     = 32'd0;
        bus.req_wdata    = 32'd0;
        bus.mem_ready    = 1'b0;
        bus.mem_rdata    = 32'hDEAD_BEEF;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst/req_ready", 32'(bus.req_ready), 32'd1);
        chk("rst/mem_req", 32'(bus.mem_req), 32'd0);
        chk("rst/mem_we", 32'(bus.mem_we), 32'd0);
        chk("rst/mem_wstrb", 32'(bus.mem_wstrb), 32'd0);
        chk("rst/mem_addr", bus.mem_addr, 32'd0);
        chk("rst/mem_wdata", bus.mem_wdata, 32'd0);
        chk("rst/rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("rst/rsp_data", bus.rsp_data, 32'd0);
        chk("rst/rsp_err", 32'(bus.rsp_err), 32'd0);
        @(posedge clk);
        #1;
        reset  = 1'b0;
        chk_en = 1'b1;

        // mem_ready while idle must be ignored
        bus.mem_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        bus.mem_ready = 1'b0;

        //  name        st    f3    addr          wdata         rdata        k   err   wstrb    wdata          rsp
        run("lb_1003",  1'b0, 3'd0, 32'h1003,     32'h0,        32'h80FF1234, 1, 1'b0, 4'b0000, 32'h0,         32'hFFFFFF80);
        run("sh_2002",  1'b1, 3'd1, 32'h2002,     32'hAAAABEEF, 32'h0,        2, 1'b0, 4'b1100, 32'hBEEFBEEF,  32'h0);
        run("lw_mis6",  1'b0, 3'd2, 32'h6,        32'h0,        32'h0,        1, 1'b1, 4'b0000, 32'h0,         32'h0);
        run("lhu_tmo",  1'b0, 3'd5, 32'h10,       32'h0,        32'h0,        0, 1'b1, 4'b0000, 32'h0,         32'h0);
        run("sb_1",     1'b1, 3'd0, 32'h1,        32'h5A,       32'h0,        1, 1'b0, 4'b0010, 32'h5A5A5A5A,  32'h0);
        run("lbu_1",    1'b0, 3'd4, 32'h1,        32'h0,        32'h00005A00, 1, 1'b0, 4'b0000, 32'h0,         32'h0000005A);
        run("lh_2",     1'b0, 3'd1, 32'h2,        32'h0,        32'h80010000, 3, 1'b0, 4'b0000, 32'h0,         32'hFFFF8001);
        run("sw_last",  1'b1, 3'd2, 32'h100,      32'h12345678, 32'h0,       16, 1'b0, 4'b1111, 32'h12345678,  32'h0);
        run("st_f3_3",  1'b1, 3'd3, 32'h0,        32'h0,        32'h0,        1, 1'b1, 4'b0000, 32'h0,         32'h0);
        run("ld_f3_6",  1'b0, 3'd6, 32'h0,        32'h0,        32'h0,        1, 1'b1, 4'b0000, 32'h0,         32'h0);
        run("sh_mis3",  1'b1, 3'd1, 32'h3,        32'h0,        32'h0,        1, 1'b1, 4'b0000, 32'h0,         32'h0);
        run("lbu_3",    1'b0, 3'd4, 32'h3,        32'h0,        32'hAB000000, 1, 1'b0, 4'b0000, 32'h0,         32'h000000AB);
        run("lh_0",     1'b0, 3'd1, 32'h0,        32'h0,        32'h12347FFF, 2, 1'b0, 4'b0000, 32'h0,         32'h00007FFF);
        run("sb_3",     1'b1, 3'd0, 32'h3,        32'h123456C3, 32'h0,        1, 1'b0, 4'b1000, 32'hC3C3C3C3,  32'h0);
        run("lw_8",     1'b0, 3'd2, 32'h8,        32'h0,        32'hCAFEF00D, 4, 1'b0, 4'b0000, 32'h0,         32'hCAFEF00D);

        // Reset during the third WAIT cycle of a word load, with mem_ready in the same cycle.
        bus.req_valid    = 1'b1;
        bus.req_is_store = 1'b0;
        bus.req_funct3   = 3'd2;
        bus.req_addr     = 32'h20;
        @(posedge clk);
        #1;
        tr_acc   = cyc;
        tr_mem   = 1'b1;
        tr_k     = 1000;
        tr_rsp_c = 1000;
        tr_we    = 1'b0;
        tr_addr  = 32'h20;
        tr_wstrb = 4'b0000;
        bus.req_valid = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        chk_en        = 1'b0;
        reset         = 1'b1;
        bus.mem_ready = 1'b1;
        bus.mem_rdata = 32'h11223344;
        @(posedge clk);
        #1;
        reset         = 1'b0;
        bus.mem_ready = 1'b0;
        @(negedge clk);
        chk("abort/mem_req", 32'(bus.mem_req), 32'd0);
        chk("abort/rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("abort/req_ready", 32'(bus.req_ready), 32'd1);
        seen = 1'b0;
        repeat (20) begin
            @(negedge clk);
            if (bus.rsp_valid || bus.mem_req) seen = 1'b1;
        end
        chk("abort/quiet", 32'(seen), 32'd0);

        // Reset and a legal request in the same cycle: the request is dropped.
        @(posedge clk);
        #1;
        bus.req_valid  = 1'b1;
        bus.req_funct3 = 3'd2;
        bus.req_addr   = 32'h40;
        reset          = 1'b1;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        reset         = 1'b0;
        @(negedge clk);
        chk("prio/req_ready", 32'(bus.req_ready), 32'd1);
        chk("prio/mem_req", 32'(bus.mem_req), 32'd0);
        @(negedge clk);
        chk("prio/mem_req2", 32'(bus.mem_req), 32'd0);
        chk("prio/rsp_valid", 32'(bus.rsp_valid), 32'd0);

        @(posedge clk);
        #1;
        tr_acc = -100000;
        tr_mem = 1'b0;
        chk_en = 1'b1;
        run("lw_after", 1'b0, 3'd2, 32'h44, 32'h0, 32'h0BADCAFE, 2, 1'b0, 4'b0000, 32'h0, 32'h0BADCAFE);
        repeat (3) @(posedge clk);
        #1;
        chk_en = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end
endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 16: WAIT_MEM cycles without mem_ready before a bus-error response; legal range 1..255.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port req_valid  input  1  access request from the control FSM.
REQ-005 SHALL have port req_ready  output  1  unit can accept a request this cycle.
REQ-006 SHALL have port req_is_store  input  1  1 = store, 0 = load.
REQ-007 SHALL have port req_funct3  input  3  RV32I funct3 (LB/LH/LW/LBU/LHU, SB/SH/SW).
REQ-008 SHALL have port req_addr  input  32  byte address from the ALU result.
REQ-009 SHALL have port req_wdata  input  32  store data (rs2).
REQ-010 SHALL have port mem_req  output  1  memory access strobe.
REQ-011 SHALL have port mem_we  output  1  write enable.
REQ-012 SHALL have port mem_addr  output  32  word-aligned address, bits [1:0] = 0.
REQ-013 SHALL have port mem_wstrb  output  4  byte-lane write strobes.
REQ-014 SHALL have port mem_wdata  output  32  lane-replicated store data.
REQ-015 SHALL have port mem_ready  input  1  memory completion, sampled only while mem_req=1.
REQ-016 SHALL have port mem_rdata  input  32  read word, valid when mem_ready=1.
REQ-017 SHALL have port rsp_valid  output  1  one-cycle response pulse.
REQ-018 SHALL have port rsp_data  output  32  formatted load result; 0 for stores and errors.
REQ-019 SHALL have port rsp_err  output  1  misaligned, illegal funct3, or timeout; valid with rsp_valid.

Function
REQ-020 SHALL implement a three-state FSM: IDLE, WAIT_MEM, RESP.
REQ-021 SHALL drive req_ready=1 only in IDLE; accept on req_valid && req_ready and latch is_store, funct3, addr, wdata.
REQ-022 SHALL flag an error on acceptance for: half access with addr[0]=1; word access with addr[1:0]!=0; load funct3 in {3,6,7}; store funct3 >2. Error goes IDLE->RESP with no mem_req.
REQ-023 SHALL otherwise go IDLE->WAIT_MEM; registered mem_req=1 from the next cycle; mem_addr, mem_we, mem_wstrb, mem_wdata stable until exit.
REQ-024 SHALL, in WAIT_MEM with mem_ready=1, capture mem_rdata, drop mem_req next cycle, go to RESP.
REQ-025 SHALL count WAIT_MEM cycles in an 8-bit counter cleared on entry; if TIMEOUT_CYCLES cycles elapse without mem_ready, go to RESP with rsp_err=1. mem_ready in the final counted cycle wins over timeout.
REQ-026 SHALL assert rsp_valid exactly one cycle in RESP, then return to IDLE; no new request accepted in RESP.
REQ-027 SHALL give latency accept edge N -> mem_req cycle N+1 -> rsp_valid cycle N+1+k, k = first mem_ready cycle count (min 1); error path rsp_valid at N+1.
REQ-028 SHALL format loads: LB/LBU select byte lane addr[1:0]; LH/LHU select half lane addr[1]; LB/LH sign-extend, LBU/LHU zero-extend; LW passes through.
REQ-029 SHALL set mem_wstrb: SB 4'b0001<<addr[1:0]; SH 4'b0011<<{addr[1],1'b0}; SW 4'b1111; loads 4'b0000.
REQ-030 SHALL set mem_wdata: SB byte replicated x4; SH half replicated x2; SW unchanged.
REQ-031 SHALL ignore mem_ready when mem_req=0.

Reset
REQ-032 SHALL on reset enter IDLE next edge: req_ready=1, mem_req=0, mem_we=0, mem_wstrb=0, mem_addr=0, mem_wdata=0, rsp_valid=0, rsp_data=0, rsp_err=0, counter=0.
REQ-033 SHALL abort an in-flight access on reset with no rsp_valid; mem_req low the cycle after reset is sampled.
REQ-034 SHALL give reset priority over every other same-cycle event, including req_valid and mem_ready.

Verification
REQ-035 LB addr 0x1003, mem_rdata 0x80FF_1234, mem_ready on 1st WAIT cycle -> mem_addr 0x1000, rsp_data 0xFFFF_FF80, rsp_err 0, rsp_valid at accept+2.
REQ-036 SH addr 0x2002, wdata 0xAAAA_BEEF -> mem_we 1, mem_wstrb 4'b1100, mem_wdata 0xBEEF_BEEF, rsp_data 0.
REQ-037 LW addr 0x0000_0006 -> no mem_req, rsp_valid at accept+1, rsp_err 1, rsp_data 0.
REQ-038 LHU addr 0x10, mem_ready never asserted, TIMEOUT_CYCLES=16 -> mem_req high exactly 16 cycles, then rsp_err 1.
REQ-039 Reset on 3rd WAIT_MEM cycle of LW -> mem_req 0 next cycle, no rsp_valid, req_ready 1.
REQ-040 Back-to-back SB addr 0x1 (wdata 0x5A) then LBU addr 0x1 (rdata 0x0000_5A00) -> wstrb 4'b0010, wdata 0x5A5A_5A5A; then rsp_data 0x0000_005A.
